// File: rtl/dma_st_byte_unpacker.sv
// dma_st_byte_unpacker
// Takes 32-bit Avalon-ST beats from the HPS DMA source, buffers them in a small
// beat FIFO and replays them as an 8-bit Avalon-ST byte stream with packet
// framing. The first byte of a beat is in [31:24]. On the final beat, 'empty'
// drops the trailing bytes. Framing errors set sticky flags, and the block
// recovers from them on its own. Packet and byte counters feed the downstream
// datapath.
module dma_st_byte_unpacker #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk_clk,
  input  logic             rst_reset_n,
  input  logic [31:0]      snk_data,
  input  logic             snk_valid,
  output logic             snk_ready,
  input  logic             snk_startofpacket,
  input  logic             snk_endofpacket,
  input  logic [1:0]       snk_empty,
  output logic [7:0]       src_data,
  output logic             src_valid,
  input  logic             src_ready,
  output logic             src_startofpacket,
  output logic             src_endofpacket,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] stat_pkt_count,
  output logic [CNT_W-1:0] stat_byte_count,
  output logic             stat_err_nosop,
  output logic             stat_err_dupsop,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  beat_t         mem [FIFO_DEPTH];
  beat_t         head, new_beat;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [0:0]    state, state_nxt;
  logic [1:0]    k, last_k;
  logic [4:0]    sh;
  logic          full, not_empty, accept, push, pop, xfer;
  logic          nosop, dupsop;

  // Full is a decode of the registered count only, so src_ready never reaches snk_ready.
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign not_empty = (count != '0);
  assign snk_ready = rst_reset_n & ~full;
  assign accept    = snk_valid & snk_ready;

  // Empty has no meaning on a non-eop beat; store 0 so that unpacking never sees it.
  assign new_beat = '{data: snk_data, sop: snk_startofpacket, eop: snk_endofpacket,
                      empty: snk_endofpacket ? snk_empty : 2'd0};

  // Input framing: decide push/drop, next state and framing errors for an accepted beat.
  always_comb begin
    push      = 1'b0;
    nosop     = 1'b0;
    dupsop    = 1'b0;
    state_nxt = state;
    if (accept) begin
      if (state == IDLE) begin
        if (snk_startofpacket) begin
          push      = 1'b1;
          state_nxt = snk_endofpacket ? IDLE : IN_PKT;
        end else begin
          nosop = 1'b1;          // stray beat: swallowed, never pushed
        end
      end else begin
        push   = 1'b1;
        dupsop = snk_startofpacket; // restarts the packet; the old one loses its eop
        if (snk_endofpacket) state_nxt = IDLE;
      end
    end
  end

  // Output unpacking of the FIFO head by byte index k (~k == 3-k for 2 bits).
  assign head              = mem[rd_ptr];
  assign last_k            = head.eop ? ~head.empty : 2'd3;
  assign sh                = {~k, 3'b000};
  assign src_valid         = not_empty;
  assign src_data          = not_empty ? head.data[sh +: 8] : 8'h00;
  assign src_startofpacket = not_empty & head.sop & (k == 2'd0);
  assign src_endofpacket   = not_empty & head.eop & (k == last_k);
  assign xfer              = not_empty & src_ready;
  assign pop               = xfer & (k == last_k);
  assign busy              = not_empty | (state == IN_PKT);

  // Beat storage; writes only happen out of reset because snk_ready is gated by it.
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= new_beat;
  end

  // FIFO pointers, occupancy, byte index and framing state.
  always_ff @(posedge clk_clk) begin
    if (!rst_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      k      <= 2'd0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (xfer) k <= pop ? 2'd0 : k + 2'd1;
      state <= state_nxt;
    end
  end

  // Statistics: clear beats a same-cycle increment, but a same-cycle error still sticks.
  always_ff @(posedge clk_clk) begin
    if (!rst_reset_n) begin
      stat_pkt_count  <= '0;
      stat_byte_count <= '0;
      stat_err_nosop  <= 1'b0;
      stat_err_dupsop <= 1'b0;
    end else begin
      if (stat_clear) begin
        stat_pkt_count  <= '0;
        stat_byte_count <= '0;
      end else begin
        if (xfer)                   stat_byte_count <= stat_byte_count + 1'b1;
        if (xfer & src_endofpacket) stat_pkt_count  <= stat_pkt_count + 1'b1;
      end
      stat_err_nosop  <= nosop  | (stat_err_nosop  & ~stat_clear);
      stat_err_dupsop <= dupsop | (stat_err_dupsop & ~stat_clear);
    end
  end

endmodule

// File: tb/tb_dma_st_byte_unpacker.sv
// Bench for dma_st_byte_unpacker: a queue model of the expected byte stream is
// checked every cycle. Directed cases pin literal values, and a randomized phase
// exercises backpressure, framing errors, clears and counter wrap.
module tb_dma_st_byte_unpacker;
  localparam int DEPTH = 4;
  localparam int CW    = 6;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [31:0]   snk_data = '0;
  logic          snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
  logic [1:0]    snk_empty = '0;
  logic          snk_ready;
  logic [7:0]    src_data;
  logic          src_valid, src_sop, src_eop;
  logic          src_ready = 1'b1;
  logic          stat_clear = 1'b0;
  logic [CW-1:0] pkt_cnt, byte_cnt;
  logic          err_nosop, err_dupsop, busy;

  always #5 clk = ~clk;

  dma_st_byte_unpacker #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_clk(clk), .rst_reset_n(rst_n),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .snk_startofpacket(snk_sop), .snk_endofpacket(snk_eop), .snk_empty(snk_empty),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_startofpacket(src_sop), .src_endofpacket(src_eop),
    .stat_clear(stat_clear), .stat_pkt_count(pkt_cnt), .stat_byte_count(byte_cnt),
    .stat_err_nosop(err_nosop), .stat_err_dupsop(err_dupsop), .busy(busy));

  typedef struct packed {logic [7:0] d; logic s; logic e; logic lastb;} exp_t;

  int            n_chk = 0, n_fail = 0;
  exp_t          q[$];
  logic [9:0]    got[$];          // {sop, eop, data} of each src transfer
  int            mbeats = 0;
  bit            min_pkt = 0, m_nosop = 0, m_dupsop = 0, rst_seen = 0;
  logic [CW-1:0] m_pkt = '0, m_bytes = '0;
  int            rdy_mode = 0;    // 0: ready, 1: random, 2: stalled
  bit            clr_rand = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference model: expected bytes are derived from accepted beats by the framing rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_snk_ready", snk_ready, 0);
      if (rst_seen) begin
        chk("rst_src_ctl", {src_valid, src_sop, src_eop}, 0);
        chk("rst_src_data", src_data, 0);
        chk("rst_counts", {pkt_cnt, byte_cnt}, 0);
        chk("rst_flags", {err_nosop, err_dupsop, busy}, 0);
      end
      rst_seen = 1; q.delete(); mbeats = 0; min_pkt = 0;
      m_pkt = '0; m_bytes = '0; m_nosop = 0; m_dupsop = 0;
    end else begin
      bit nos, dup;
      int n;
      rst_seen = 0; nos = 0; dup = 0;
      chk("snk_ready", snk_ready, mbeats < DEPTH);
      chk("src_valid", src_valid, q.size() != 0);
      if (src_valid && q.size() != 0)
        chk("src_byte", {src_data, src_sop, src_eop}, {q[0].d, q[0].s, q[0].e});
      chk("pkt_count", pkt_cnt, m_pkt);
      chk("byte_count", byte_cnt, m_bytes);
      chk("err_flags", {err_nosop, err_dupsop}, {m_nosop, m_dupsop});
      chk("busy", busy, (mbeats > 0) || min_pkt);
      if (src_valid && src_ready && q.size() != 0) begin
        got.push_back({src_sop, src_eop, src_data});
        m_bytes++;
        if (q[0].e) m_pkt++;
        if (q[0].lastb) mbeats--;
        void'(q.pop_front());
      end
      if (snk_valid && snk_ready) begin
        bit keep;
        keep = min_pkt || snk_sop;
        if (!min_pkt && !snk_sop) nos = 1;
        if (min_pkt && snk_sop) dup = 1;
        if (keep) begin
          n = snk_eop ? 4 - int'(snk_empty) : 4;
          for (int i = 0; i < n; i++)
            q.push_back('{d: snk_data[31-8*i -: 8], s: snk_sop && i == 0,
                          e: snk_eop && i == n-1, lastb: i == n-1});
          mbeats++;
          min_pkt = !snk_eop;
        end
      end
      if (stat_clear) begin
        m_pkt = '0; m_bytes = '0; m_nosop = 0; m_dupsop = 0;
      end
      if (nos) m_nosop = 1;
      if (dup) m_dupsop = 1;
    end
  end

  // Downstream ready and random clear drivers.
  always @(posedge clk) begin
    #1;
    src_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
    if (clr_rand) stat_clear = ($urandom_range(0, 999) == 0);
  end

  // All tasks start and end at posedge+#1.
  task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
    bit acc;
    snk_data = d; snk_sop = s; snk_eop = e; snk_empty = em; snk_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); acc = snk_ready;
      @(posedge clk); #1;
      if (acc) begin snk_valid = 1'b0; return; end
    end
    snk_valid = 1'b0; n_chk++; n_fail++;
    $display("FAIL send_timeout: got snk_ready=0 for 300 cycles expected acceptance");
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !src_valid) begin @(posedge clk); #1; return; end
      @(posedge clk); #1;
    end
    n_chk++; n_fail++;
    $display("FAIL drain_timeout: got src_valid still 1 expected drained");
  endtask

  task automatic pulse_clear();
    stat_clear = 1'b1; @(posedge clk); #1; stat_clear = 1'b0;
  endtask

  initial begin
    logic [7:0] t2 [9];
    t2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single beat, first byte one cycle after acceptance
    pulse_clear(); got.delete();
    snk_data = 32'hA1B2C3D4; snk_sop = 1; snk_eop = 1; snk_empty = 0; snk_valid = 1;
    @(negedge clk);
    chk("t1_accept", snk_ready, 1);
    chk("t1_not_yet", src_valid, 0);
    @(posedge clk); #1 snk_valid = 0;
    @(negedge clk);
    chk("t1_first", {src_valid, src_sop, src_eop, src_data}, {3'b110, 8'hA1});
    @(posedge clk); #1;
    drain();
    chk("t1_len", got.size(), 4);
    chk("t1_b0", got[0], {2'b10, 8'hA1});
    chk("t1_b3", got[3], {2'b01, 8'hD4});
    chk("t1_stats", {pkt_cnt, byte_cnt}, {6'd1, 6'd4});

    // 2: empty=3 on last beat
    pulse_clear(); got.delete();
    send(32'h11223344, 1, 0, 2'd2);
    send(32'h55667788, 0, 0, 2'd1);
    send(32'h99AABBCC, 0, 1, 2'd3);
    drain();
    chk("t2_len", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) chk("t2_data", got[i][7:0], t2[i]);
    chk("t2_eop", got[8][9:8], 2'b01);
    chk("t2_stats", {pkt_cnt, byte_cnt}, {6'd1, 6'd9});

    // 3: FIFO fills under backpressure, nothing lost
    pulse_clear(); got.delete(); rdy_mode = 2;
    fork
      for (int i = 0; i < 5; i++)
        send(32'h00010203 + 32'h04040404 * i, i == 0, i == 4, 2'd0);
      begin
        repeat (8) @(negedge clk);
        chk("t3_full", snk_ready, 0);
        chk("t3_hold", {src_valid, src_data}, {1'b1, 8'h00});
        rdy_mode = 0;
      end
    join
    drain();
    chk("t3_len", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("t3_order", got[i][7:0], i);

    // 4: stray beat outside a packet
    pulse_clear(); got.delete();
    send(32'h12345678, 0, 0, 2'd0);
    send(32'hDEADBEEF, 1, 1, 2'd0);
    drain();
    chk("t4_nosop", {err_nosop, err_dupsop}, 2'b10);
    chk("t4_len", got.size(), 4);
    chk("t4_b0", got[0], {2'b10, 8'hDE});
    chk("t4_b3", got[3], {2'b01, 8'hEF});
    chk("t4_pkt", pkt_cnt, 1);

    // 5: duplicate sop truncates the open packet
    pulse_clear(); got.delete();
    chk("t5_cleared", {err_nosop, err_dupsop}, 2'b00);
    send(32'h10111213, 1, 0, 2'd0);
    send(32'h20212223, 0, 0, 2'd0);
    send(32'h30313233, 1, 1, 2'd0);
    drain();
    chk("t5_dupsop", {err_nosop, err_dupsop}, 2'b01);
    chk("t5_len", got.size(), 12);
    chk("t5_b7", got[7], {2'b00, 8'h23});
    chk("t5_b8", got[8], {2'b10, 8'h30});
    chk("t5_b11", got[11], {2'b01, 8'h33});
    chk("t5_pkt", pkt_cnt, 1);

    // 6: reset mid-packet discards buffered beats
    rdy_mode = 2;
    send(32'h01020304, 1, 0, 2'd0);
    send(32'h05060708, 0, 0, 2'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1; rdy_mode = 0;
    @(negedge clk);
    chk("t6_valid", src_valid, 0);
    chk("t6_counts", {pkt_cnt, byte_cnt}, 0);
    chk("t6_busy", busy, 0);
    @(posedge clk); #1;
    got.delete();
    send(32'hCAFEF00D, 1, 1, 2'd1);
    drain();
    chk("t6_len", got.size(), 3);
    chk("t6_b0", got[0], {2'b10, 8'hCA});
    chk("t6_b2", got[2], {2'b01, 8'hF0});

    // Random traffic: backpressure, gaps, stray beats, dupsop, clears, counter wrap
    rdy_mode = 1; clr_rand = 1;
    for (int p = 0; p < 300; p++) begin
      int r, nb;
      r = $urandom_range(0, 19);
      if (r == 0) send($urandom, 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)));
      if (r == 1) send($urandom, 1, 0, 2'($urandom_range(0, 3)));
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send($urandom, b == 0, b == nb - 1, 2'($urandom_range(0, 3)));
      end
    end
    clr_rand = 0; stat_clear = 0; rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
